id_regfile_scoreboard: RTL and testbench
========================================

// Module: id_regfile_scoreboard
// PURPOSE
// - Parametrised register file for the ID stage, with NRD combinational read ports and one write port.
// - Integrated busy-bit scoreboard: a register is busy from producer issue until its write-back.
// - Write-to-read bypass and a branch equality compare on ports 0/1.
// - Sits between the IF/ID register and the ID/EX register; wb-stage write port driven from MEM/WB.
// PARAMETERS
// DW        32  data width per register
// NREG      32  number of registers (power of 2); AW = $clog2(NREG)
// NRD       2   number of read ports (>=2)
// ZERO_REG  1   1: register 0 reads 0, ignores writes, never busy
// BYPASS    1   1: same-cycle write data forwarded to matching read ports
// INIT_MODE 0   reset contents: 0 = all zero, 1 = reg[i] = i
// PORTS
// clk      in  1       clock, all state updates on rising edge
// rst_n    in  1       asynchronous active-low reset
// rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
// rd_data  out NRD*DW  read data, port k at [k*DW +: DW]
// rd_busy  out NRD     port k source has a pending producer (not bypassed)
// hazard   out 1       OR of rd_busy; ID-stage stall request
// equal    out 1       rd_data port0 == rd_data port1 (after bypass)
// wr_en    in  1       write-back strobe
// wr_addr  in  AW      write-back destination
// wr_data  in  DW      write-back data
// iss_en   in  1       instruction with destination leaves ID this cycle
// iss_addr in  AW      destination of issuing instruction
// busy_cnt out AW+1    number of busy registers
// BEHAVIOUR
// - Reset (async on rst_n low, released synchronously by design integration):
//   - regs per INIT_MODE; all busy bits 0; busy_cnt = 0.
//   - Outputs then follow combinationally from state.
// - Write: on rising edge, if wr_en and !(ZERO_REG && wr_addr==0): reg[wr_addr] <= wr_data. Latency 1 cycle.
// - Read: combinational, 0 cycle latency.
//   - ZERO_REG and addr 0 -> 0.
//   - Else if BYPASS && wr_en && wr_addr==rd_addr -> wr_data.
//   - Else reg[rd_addr].
// - Scoreboard update, per register r, at each rising edge:
//   - set   = iss_en && iss_addr==r
//   - clr   = wr_en && wr_addr==r
//   - set && clr (same reg, same cycle) -> busy stays/becomes 1: the new producer wins.
//   - set only -> 1; clr only -> 0; neither -> hold.
//   - Set on an already-busy reg is legal (WAW): stays 1, the first write-back clears it.
//   - ZERO_REG: busy[0] is constant 0.
// - rd_busy[k] = busy[rd_addr_k] && !(BYPASS && wr_en && wr_addr==rd_addr_k).
//   - Bypass hides the hazard in the write-back cycle.
// - equal uses post-bypass data; valid for any NRD >= 2.
// - busy_cnt is a registered population count of busy bits, updated in the same edge as busy.
//   - Max NREG (or NREG-1 with ZERO_REG).
//   - Must never wrap: width AW+1.
// - No other storage; no X on outputs after reset for any in-range address.
// TESTING
// - Reset with INIT_MODE=1, read r5/r31 -> 5/31; busy_cnt=0, hazard=0; rst_n low mid-run clears busy.
// - wr_en r3=0xDEADBEEF, read r3 same cycle -> 0xDEADBEEF via bypass; BYPASS=0 -> old value, new next cycle.
// - Write r0=0x1234, ZERO_REG=1 -> r0 reads 0; iss_en r0 -> busy_cnt stays 0.
// - iss r7, read r7 next cycle -> rd_busy=1, hazard=1.
//   - wr r7 -> rd_busy=0 that cycle; busy_cnt 1 -> 0.
// - Same cycle iss r9 and wr r9 -> busy[9]=1 after edge.
//   - iss r9 twice, then one wr r9 -> busy[9]=0.
// - NRD=3, regs r1=r2=0x10 -> equal=1; r2=0x11 -> equal=0; issue all 31 regs -> busy_cnt=31.

Source files
------------

// File: rtl/id_regfile_scoreboard.sv
// ID-stage register file with NRD combinational read ports, one write-back port,
// same-cycle write bypass, per-register busy scoreboard and a port 0/1 equality compare.
module id_regfile_scoreboard #(
   parameter int DW        = 32,
   parameter int NREG      = 32,
   parameter int NRD       = 2,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1,
   parameter int INIT_MODE = 0,
   localparam int AW       = $clog2(NREG),
   localparam int CW       = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*DW-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   output logic              hazard,
   output logic              equal,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   output logic [CW-1:0]     busy_cnt
);

   logic [DW-1:0]   regs_q [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [CW-1:0]   busy_cnt_q;
   logic [CW-1:0]   busy_cnt_d;
   logic            wr_ok;

   assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

   // A producer issuing in the same cycle as an older write-back to the same
   // register keeps the bit set: the new producer's result is still pending.
   always_comb begin
      busy_d     = busy_q;
      busy_cnt_d = '0;
      for (int r = 0; r < NREG; r++) begin
         busy_d[r] = (iss_en && (iss_addr == AW'(r))) ||
                     (busy_q[r] && !(wr_en && (wr_addr == AW'(r))));
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= (INIT_MODE == 1) ? DW'(i) : '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         if (wr_ok) regs_q[wr_addr] <= wr_data;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          byp;
      logic          zero;
      assign addr = rd_addr[k*AW +: AW];
      assign byp  = (BYPASS != 0) && wr_en && (wr_addr == addr);
      assign zero = (ZERO_REG != 0) && (addr == '0);
      assign rd_data[k*DW +: DW] = zero ? '0 : (byp ? wr_data : regs_q[addr]);
      assign rd_busy[k]          = busy_q[addr] && !byp;
   end

   assign hazard   = |rd_busy;
   assign equal    = (rd_data[0 +: DW] == rd_data[DW +: DW]);
   assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed bench: instance A (NRD=3, bypass, reg[i]=i at reset) and
// instance B (NRD=2, no bypass, zero at reset) share clock and reset.
module tb_id_regfile_scoreboard;

   logic clk;
   logic rst_n;

   logic [14:0] a_rd_addr;
   logic [95:0] a_rd_data;
   logic [2:0]  a_rd_busy;
   logic        a_hazard, a_equal;
   logic        a_wr_en, a_iss_en;
   logic [4:0]  a_wr_addr, a_iss_addr;
   logic [31:0] a_wr_data;
   logic [5:0]  a_busy_cnt;

   logic [9:0]  b_rd_addr;
   logic [63:0] b_rd_data;
   logic [1:0]  b_rd_busy;
   logic        b_hazard, b_equal;
   logic        b_wr_en, b_iss_en;
   logic [4:0]  b_wr_addr, b_iss_addr;
   logic [31:0] b_wr_data;
   logic [5:0]  b_busy_cnt;

   int checks;
   int errors;

   id_regfile_scoreboard #(
      .DW(32), .NREG(32), .NRD(3), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .hazard(a_hazard), .equal(a_equal),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .iss_en(a_iss_en), .iss_addr(a_iss_addr), .busy_cnt(a_busy_cnt)
   );

   id_regfile_scoreboard #(
      .DW(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(0), .INIT_MODE(0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .hazard(b_hazard), .equal(b_equal),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .iss_en(b_iss_en), .iss_addr(b_iss_addr), .busy_cnt(b_busy_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change at a falling edge; step returns at the next falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
      a_iss_en = 1'b0; a_iss_addr = '0;
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
      b_iss_en = 1'b0; b_iss_addr = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      a_rd_addr = '0;
      b_rd_addr = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset contents and scoreboard
      a_rd_addr[0 +: 5] = 5'd5;
      a_rd_addr[5 +: 5] = 5'd31;
      b_rd_addr[0 +: 5] = 5'd5;
      settle();
      check("rst_a_r5", a_rd_data[0 +: 32], 64'd5);
      check("rst_a_r31", a_rd_data[32 +: 32], 64'd31);
      check("rst_a_cnt", a_busy_cnt, 64'd0);
      check("rst_a_haz", a_hazard, 64'd0);
      check("rst_a_eq", a_equal, 64'd0);
      check("rst_b_r5", b_rd_data[0 +: 32], 64'd0);

      // write with and without bypass
      a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hDEADBEEF;
      b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'hDEADBEEF;
      a_rd_addr[0 +: 5] = 5'd3;
      b_rd_addr[0 +: 5] = 5'd3;
      settle();
      check("byp_a_r3", a_rd_data[0 +: 32], 64'hDEADBEEF);
      check("nobyp_b_r3", b_rd_data[0 +: 32], 64'd0);
      step();
      idle_inputs();
      settle();
      check("wr_a_r3", a_rd_data[0 +: 32], 64'hDEADBEEF);
      check("wr_b_r3", b_rd_data[0 +: 32], 64'hDEADBEEF);

      // register zero ignores writes and issues
      step();
      a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h1234;
      a_iss_en = 1'b1; a_iss_addr = 5'd0;
      a_rd_addr[0 +: 5] = 5'd0;
      settle();
      check("zero_a_byp", a_rd_data[0 +: 32], 64'd0);
      step();
      idle_inputs();
      settle();
      check("zero_a_rd", a_rd_data[0 +: 32], 64'd0);
      check("zero_a_cnt", a_busy_cnt, 64'd0);
      check("zero_a_busy", a_rd_busy[0], 64'd0);

      // issue r7 then write it back
      step();
      a_iss_en = 1'b1; a_iss_addr = 5'd7;
      b_iss_en = 1'b1; b_iss_addr = 5'd7;
      step();
      idle_inputs();
      a_rd_addr[0 +: 5] = 5'd7;
      b_rd_addr[0 +: 5] = 5'd7;
      settle();
      check("iss7_a_busy", a_rd_busy[0], 64'd1);
      check("iss7_a_haz", a_hazard, 64'd1);
      check("iss7_a_cnt", a_busy_cnt, 64'd1);
      check("iss7_b_busy", b_rd_busy[0], 64'd1);
      step();
      a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h77;
      b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'h77;
      settle();
      check("wb7_a_busy", a_rd_busy[0], 64'd0);
      check("wb7_a_haz", a_hazard, 64'd0);
      check("wb7_a_data", a_rd_data[0 +: 32], 64'h77);
      check("wb7_a_cnt", a_busy_cnt, 64'd1);
      check("wb7_b_busy", b_rd_busy[0], 64'd1);
      check("wb7_b_haz", b_hazard, 64'd1);
      step();
      idle_inputs();
      settle();
      check("clr7_a_cnt", a_busy_cnt, 64'd0);
      check("clr7_b_busy", b_rd_busy[0], 64'd0);
      check("clr7_b_data", b_rd_data[0 +: 32], 64'h77);

      // same-cycle issue and write-back: new producer wins
      a_rd_addr[0 +: 5] = 5'd9;
      a_iss_en = 1'b1; a_iss_addr = 5'd9;
      a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
      step();
      idle_inputs();
      settle();
      check("sim9_a_busy", a_rd_busy[0], 64'd1);
      check("sim9_a_cnt", a_busy_cnt, 64'd1);
      a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h9A;
      step();
      idle_inputs();
      settle();
      check("sim9_clr_cnt", a_busy_cnt, 64'd0);

      // WAW: two issues, one write-back clears
      a_iss_en = 1'b1; a_iss_addr = 5'd9;
      step();
      step();
      idle_inputs();
      settle();
      check("waw9_a_busy", a_rd_busy[0], 64'd1);
      check("waw9_a_cnt", a_busy_cnt, 64'd1);
      a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h9B;
      step();
      idle_inputs();
      settle();
      check("waw9_clr_busy", a_rd_busy[0], 64'd0);
      check("waw9_clr_cnt", a_busy_cnt, 64'd0);
      check("waw9_data", a_rd_data[0 +: 32], 64'h9B);

      // equality compare on ports 0/1
      a_wr_en = 1'b1; a_wr_addr = 5'd1; a_wr_data = 32'h10;
      step();
      a_wr_addr = 5'd2; a_wr_data = 32'h10;
      step();
      idle_inputs();
      a_rd_addr[0 +: 5] = 5'd1;
      a_rd_addr[5 +: 5] = 5'd2;
      a_rd_addr[10 +: 5] = 5'd3;
      settle();
      check("eq_a_same", a_equal, 64'd1);
      check("eq_a_p2", a_rd_data[64 +: 32], 64'hDEADBEEF);
      a_wr_en = 1'b1; a_wr_addr = 5'd2; a_wr_data = 32'h11;
      settle();
      check("eq_a_byp", a_equal, 64'd0);
      check("eq_a_byp_p1", a_rd_data[32 +: 32], 64'h11);
      step();
      idle_inputs();
      settle();
      check("eq_a_diff", a_equal, 64'd0);

      // issue every register (r0 included, must not count)
      for (int r = 0; r < 32; r++) begin
         a_iss_en = 1'b1; a_iss_addr = 5'(r);
         step();
      end
      idle_inputs();
      a_rd_addr[0 +: 5] = 5'd4;
      settle();
      check("all_a_cnt", a_busy_cnt, 64'd31);
      check("all_a_haz", a_hazard, 64'd1);
      check("all_a_busy", a_rd_busy, 64'b111);

      // asynchronous reset mid-run
      #2;
      rst_n = 1'b0;
      a_rd_addr[0 +: 5] = 5'd3;
      settle();
      check("arst_a_cnt", a_busy_cnt, 64'd0);
      check("arst_a_haz", a_hazard, 64'd0);
      check("arst_a_r3", a_rd_data[0 +: 32], 64'd3);
      step();
      rst_n = 1'b1;
      step();
      settle();
      check("post_rst_a_cnt", a_busy_cnt, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
